branch_update: RTL
==================

// Module: branch_update
// PURPOSE
//  EX-stage branch resolution and predictor write side; IF stage performs the predictor read.
//  Compares the actual next PC of each resolved branch with the prediction carried down the pipe.
//  Drives the correction signals consumed by IF next-PC selection: preright, branch, redirect PC.
//  Issues one registered write per resolved branch into the 2**IDX_W-entry BTB:
//  counter update on hit, round-robin allocation on taken miss.
// PARAMETERS
//  IDX_W      3    BTB index width; entries = 2**IDX_W
//  PC_W       32   PC / target width
// PORTS
//  clk          in   1      clock, rising edge
//  RST          in   1      synchronous active-high reset
//  stall        in   1      pipeline stall; EX instruction held, no update issued
//  ex_valid     in   1      EX slot holds a real instruction
//  ex_branch    in   1      EX instruction is a branch/jump
//  ex_taken     in   1      resolved direction
//  pc_ex        in   PC_W   PC of EX instruction
//  ex_target    in   PC_W   resolved taken target
//  pc_pre_old   in   PC_W   next PC predicted in IF for this instruction
//  hit_old      in   1      BTB hit at prediction time
//  hitpos_old   in   IDX_W  BTB entry hit at prediction time
//  cnt_old      in   2      2-bit counter read at prediction time
//  branch_old   out  1      ex_valid & ex_branch (combinational)
//  preright_old out  1      prediction correct (combinational)
//  pc_npc       out  PC_W   correct next PC: ex_taken ? ex_target : pc_ex+4 (combinational)
//  btb_we       out  1      BTB write strobe (registered)
//  btb_idx      out  IDX_W  entry written
//  btb_tag      out  PC_W   branch PC stored as tag
//  btb_target   out  PC_W   target stored
//  btb_cnt      out  2      new counter value
//  br_count     out  32     resolved branches (PERF_CNT_EN)
//  miss_count   out  32     mispredictions (PERF_CNT_EN)
// BEHAVIOUR
//  - preright_old = ~branch_old | (pc_npc == pc_pre_old); pc_npc addition wraps mod 2**PC_W.
//  - Update cycle U = ex_valid & ex_branch & ~stall & ~RST; a stalled instruction is
//    written exactly once, in the first non-stalled cycle.
//  - Write outputs are registered: effects of U at edge N appear during cycle N+1, 1-cycle latency.
//  - Case hit_old=1: btb_we=1, btb_idx=hitpos_old, btb_tag=pc_ex.
//    - btb_cnt = taken ? sat_inc(cnt_old) : sat_dec(cnt_old); saturate at 3 and 0.
//    - btb_target = taken ? ex_target : previous target, so write ex_target only when taken.
//      Otherwise echo pc_pre_old's stored target; since that is unavailable, the not-taken
//      hit write carries ex_target and the IF side must honour counter-only writes when
//      btb_cnt<2.
//  - Case hit_old=0 & taken: allocate.
//    - btb_idx = rr_ptr, btb_cnt=2'b10, btb_tag=pc_ex, btb_target=ex_target.
//    - rr_ptr increments at the same edge; wraps 2**IDX_W-1 -> 0.
//  - Case hit_old=0 & ~taken: no write (btb_we=0), rr_ptr unchanged.
//  - btb_we is a single-cycle pulse; btb_idx/tag/target/cnt hold their last value when btb_we=0.
//  - Back-to-back U cycles produce back-to-back writes; no internal queue.
//  - IF reading the entry being written in the same cycle sees the old contents;
//    no bypass is provided here.
//  - Reset (sync, any cycle, including a U cycle): btb_we=0, btb_idx=0, btb_tag=0,
//    btb_target=0, btb_cnt=0, rr_ptr=0, br_count=0, miss_count=0. A pending U is
//    dropped; RST dominates.
//  - Combinational outputs do not depend on RST or stall.
// CONFIGURATION
//  BRANCH_PERF_CNT_EN defined:
//    - br_count += 1 on each U.
//    - miss_count += 1 on each U with ~preright_old.
//    - Both 32-bit and wrap at 2**32.
//  BRANCH_PERF_CNT_EN undefined: br_count and miss_count tied to 0; no counter flops.
// TESTING
//  1. RST=1 for 2 cycles -> all registered outputs 0.
//  2. Taken miss (pc_ex=0x100, target=0x200, pc_pre_old=0x104, hit_old=0):
//     -> preright_old=0, pc_npc=0x200.
//     -> Next cycle btb_we=1, idx=0, tag=0x100, target=0x200, cnt=2; rr_ptr becomes 1.
//  3. Hit, taken correct (hitpos_old=5, cnt_old=3, pc_pre_old=target=0x40):
//     -> preright_old=1; write idx=5, cnt=3 (saturates).
//  4. Hit, not taken (cnt_old=0, pc_ex=0x80, pc_pre_old=0x84):
//     -> preright_old=1, cnt=0.
//     -> With pc_pre_old=0x300 instead: preright_old=0, pc_npc=0x84.
//  5. 9 consecutive taken misses -> btb_idx 0..7 then 0 (wrap);
//     one stall=1 cycle held mid-sequence -> no extra write.
//  6. RST asserted in a U cycle -> btb_we=0 next cycle.
//     With the macro, 3 branches / 1 miss -> br_count=3, miss_count=1.

Source files
------------

// File: rtl/branch_update.sv
// branch_update: EX-stage branch resolution and BTB write side; BRANCH_PERF_CNT_EN enables perf counters
module branch_update #(
  parameter int IDX_W = 3,
  parameter int PC_W  = 32
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             stall,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic             ex_taken,
  input  logic [PC_W-1:0]  pc_ex,
  input  logic [PC_W-1:0]  ex_target,
  input  logic [PC_W-1:0]  pc_pre_old,
  input  logic             hit_old,
  input  logic [IDX_W-1:0] hitpos_old,
  input  logic [1:0]       cnt_old,
  output logic             branch_old,
  output logic             preright_old,
  output logic [PC_W-1:0]  pc_npc,
  output logic             btb_we,
  output logic [IDX_W-1:0] btb_idx,
  output logic [PC_W-1:0]  btb_tag,
  output logic [PC_W-1:0]  btb_target,
  output logic [1:0]       btb_cnt,
  output logic [31:0]      br_count,
  output logic [31:0]      miss_count
);
  logic [IDX_W-1:0] rr_ptr;
  logic             upd;
  logic [1:0]       cnt_new;
  // resolve the branch and grade the IF prediction
  always_comb begin
    branch_old   = ex_valid & ex_branch;
    pc_npc       = ex_taken ? ex_target : pc_ex + PC_W'(4);
    preright_old = ~branch_old | (pc_npc == pc_pre_old);
    upd          = branch_old & ~stall;
    cnt_new      = ex_taken ? ((cnt_old == 2'd3) ? 2'd3 : cnt_old + 2'd1)
                            : ((cnt_old == 2'd0) ? 2'd0 : cnt_old - 2'd1);
  end
  // registered BTB write: counter update on hit, round-robin allocation on taken miss
  always_ff @(posedge clk) begin
    if (RST) begin
      btb_we     <= 1'b0;
      btb_idx    <= '0;
      btb_tag    <= '0;
      btb_target <= '0;
      btb_cnt    <= 2'd0;
      rr_ptr     <= '0;
    end else begin
      btb_we <= upd & (hit_old | ex_taken);
      if (upd & hit_old) begin
        btb_idx    <= hitpos_old;
        btb_tag    <= pc_ex;
        btb_target <= ex_target;
        btb_cnt    <= cnt_new;
      end else if (upd & ex_taken) begin
        btb_idx    <= rr_ptr;
        btb_tag    <= pc_ex;
        btb_target <= ex_target;
        btb_cnt    <= 2'b10;
        rr_ptr     <= rr_ptr + 1'b1;
      end
    end
  end
`ifdef BRANCH_PERF_CNT_EN
  // count resolved branches and mispredictions, wrapping at 2**32
  always_ff @(posedge clk) begin
    if (RST) begin
      br_count   <= '0;
      miss_count <= '0;
    end else if (upd) begin
      br_count   <= br_count + 32'd1;
      miss_count <= miss_count + {31'd0, ~preright_old};
    end
  end
`else
  assign br_count   = '0;
  assign miss_count = '0;
`endif
endmodule
